// File: rtl/vga_frame_streamer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_stream_pkg: timing defaults, FSM states and FIFO entry layout shared by
// the VGA frame streamer.            Revision: 1.0
// ---------------------------------------------------------------------------
package vga_stream_pkg;

  localparam int DEF_WIDTH      = 640;
  localparam int DEF_HEIGHT     = 480;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int DEF_H_TOTAL = DEF_WIDTH + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_HEIGHT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_CNT_W = $clog2(DEF_H_TOTAL);
  localparam int DEF_V_CNT_W = $clog2(DEF_V_TOTAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SCAN  = 2'd2
  } state_t;

  localparam int COLOR_W = 8;
  localparam int ENTRY_W = 25;
  localparam int SOF_BIT = 24;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_streamer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_frame_streamer_if: pixel input handshake plus VGA output bundle.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface vga_frame_streamer_if;
  import vga_stream_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_sof;
  logic [COLOR_W-1:0] in_r;
  logic [COLOR_W-1:0] in_g;
  logic [COLOR_W-1:0] in_b;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;
  logic               valid;
  logic               underflow;
  logic               sof_err;
  logic               frame_done;

  modport master (
    output in_valid, in_sof, in_r, in_g, in_b,
    input  in_ready, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  valid, underflow, sof_err, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b,
    output in_ready, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    output valid, underflow, sof_err, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/vga_frame_streamer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_fifo: synchronous show-ahead FIFO of {sof, r, g, b} entries.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pixel_fifo
  import vga_stream_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int            c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = DEPTH[c_aw:0];

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]    r_wr_ptr;
  logic [c_aw-1:0]    r_rd_ptr;
  logic [c_aw:0]      r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_full);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_frame_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_frame_streamer: FIFO-buffered pixel stream to VGA raster with SOF lock.
// Revision: 1.0
// ---------------------------------------------------------------------------
module vga_frame_streamer
  import vga_stream_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 reset_n,
  vga_frame_streamer_if.slave bus
);

  localparam int c_h_total = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = HEIGHT + V_FP + V_SYNC + V_BP;
  // One spare code so sync end equal to the total still fits.
  localparam int c_hw      = cnt_width(c_h_total + 1);
  localparam int c_vw      = cnt_width(c_v_total + 1);

  localparam logic [c_hw-1:0] c_h_act  = c_hw'(WIDTH);
  localparam logic [c_hw-1:0] c_h_lpix = c_hw'(WIDTH - 1);
  localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_hs_beg = c_hw'(WIDTH + H_FP);
  localparam logic [c_hw-1:0] c_hs_end = c_hw'(WIDTH + H_FP + H_SYNC);
  localparam logic [c_vw-1:0] c_v_act  = c_vw'(HEIGHT);
  localparam logic [c_vw-1:0] c_v_lpix = c_vw'(HEIGHT - 1);
  localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_vs_beg = c_vw'(HEIGHT + V_FP);
  localparam logic [c_vw-1:0] c_vs_end = c_vw'(HEIGHT + V_FP + V_SYNC);

  state_t             r_state;
  logic [c_hw-1:0]    r_h;
  logic [c_vw-1:0]    r_v;
  logic [COLOR_W-1:0] r_r, r_g, r_b;
  logic               r_hs, r_vs, r_blank_n, r_valid;
  logic               r_underflow, r_sof_err, r_frame_done;

  logic               w_in_ready, w_push, w_pop, w_full, w_empty;
  logic               w_scan, w_active, w_origin;
  logic [ENTRY_W-1:0] w_wr_data, w_rd_data;

  assign w_in_ready = reset_n && !w_full;
  // While unlocked, only a start-of-frame pixel is kept; the rest are dropped.
  assign w_push     = bus.in_valid && w_in_ready && ((r_state != IDLE) || bus.in_sof);
  assign w_scan     = (r_state == SCAN);
  assign w_active   = (r_h < c_h_act) && (r_v < c_v_act);
  assign w_origin   = (r_h == '0) && (r_v == '0);
  assign w_pop      = w_scan && w_active && !w_empty;
  assign w_wr_data  = {bus.in_sof, bus.in_r, bus.in_g, bus.in_b};

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_wr_data),
    .i_pop   (w_pop),
    .o_data  (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_h          <= '0;
      r_v          <= '0;
      r_r          <= '0;
      r_g          <= '0;
      r_b          <= '0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_blank_n    <= 1'b0;
      r_valid      <= 1'b0;
      r_underflow  <= 1'b0;
      r_sof_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_push) r_state <= PRIME;
        PRIME:   if (w_full) r_state <= SCAN;
        SCAN:    r_state <= SCAN;
        default: r_state <= IDLE;
      endcase

      if (w_scan) begin
        if (r_h == c_h_last) begin
          r_h <= '0;
          r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end

      r_r          <= w_pop ? w_rd_data[R_LSB +: COLOR_W] : '0;
      r_g          <= w_pop ? w_rd_data[G_LSB +: COLOR_W] : '0;
      r_b          <= w_pop ? w_rd_data[B_LSB +: COLOR_W] : '0;
      r_hs         <= !(w_scan && (r_h >= c_hs_beg) && (r_h < c_hs_end));
      r_vs         <= !(w_scan && (r_v >= c_vs_beg) && (r_v < c_vs_end));
      r_blank_n    <= w_scan && w_active;
      r_valid      <= w_scan && w_active;
      r_underflow  <= w_scan && w_active && w_empty;
      r_sof_err    <= w_pop && (w_rd_data[SOF_BIT] != w_origin);
      r_frame_done <= w_scan && (r_h == c_h_lpix) && (r_v == c_v_lpix);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.VGA_R       = r_r;
  assign bus.VGA_G       = r_g;
  assign bus.VGA_B       = r_b;
  assign bus.VGA_HS      = r_hs;
  assign bus.VGA_VS      = r_vs;
  assign bus.VGA_BLANK_N = r_blank_n;
  assign bus.valid       = r_valid;
  assign bus.underflow   = r_underflow;
  assign bus.sof_err     = r_sof_err;
  assign bus.frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_frame_streamer: directed bench on a 4x3 raster (7x6 totals, depth 4).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vga_frame_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int HT = 7;
  localparam int VT = 6;
  localparam int FD = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  vga_frame_streamer_if bus ();

  vga_frame_streamer #(
    .WIDTH (W), .HEIGHT (H),
    .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_FP (1), .V_SYNC (1), .V_BP (1),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: FSM state (0 idle, 1 prime, 2 scan), raster, FIFO contents.
  int          m_st = 0;
  int          m_h  = 0;
  int          m_v  = 0;
  logic [24:0] m_q[$];
  logic [24:0] src_q[$];

  int          vcnt, uf, se, fd_n, per_cyc, hs_lo, vs_lo, bl_lo, shown, rdy_lo_scan;
  bit          first_seen;
  logic [23:0] first_rgb;
  int          se_pos[$];

  function automatic logic [24:0] mkpix(input int f, input int k, input bit sof);
    return {sof, 8'(f + 1), 8'(k + 2), 8'(k + 3)};
  endfunction

  task automatic clear_stats();
    vcnt = 0; uf = 0; se = 0; fd_n = 0; per_cyc = 0;
    hs_lo = 0; vs_lo = 0; bl_lo = 0; shown = 0; rdy_lo_scan = 0;
    first_seen = 1'b0; first_rgb = '0; se_pos.delete();
  endtask

  // One clock: drive at negedge, model the posedge, compare at next negedge.
  task automatic cycle();
    logic        acc, exp_rdy, act;
    logic [24:0] px, pp;
    logic [30:0] e, a;
    int          st0;
    px = '0;
    bus.in_valid = (src_q.size() > 0);
    if (src_q.size() > 0) px = src_q[0];
    {bus.in_sof, bus.in_r, bus.in_g, bus.in_b} = px;
    #1;
    exp_rdy = reset_n && (m_q.size() < FD);
    check_eq("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    acc = bus.in_valid && bus.in_ready;
    if (m_st == 2 && bus.in_valid && !bus.in_ready) rdy_lo_scan++;
    @(posedge clk);
    e = {24'h0, 1'b1, 1'b1, 5'b0};
    if (!reset_n) begin
      m_st = 0; m_h = 0; m_v = 0; m_q.delete();
    end else begin
      st0 = m_st;
      if (m_st == 2) begin
        act  = (m_h < W) && (m_v < H);
        e[6] = (m_h != 5);
        e[5] = (m_v != 4);
        e[4] = act;
        e[3] = act;
        if (act) begin
          if (m_q.size() > 0) begin
            pp      = m_q.pop_front();
            e[30:7] = pp[23:0];
            e[1]    = pp[24] != (m_h == 0 && m_v == 0);
          end else begin
            e[2] = 1'b1;
          end
          e[0] = (m_h == W - 1) && (m_v == H - 1);
        end
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) m_v = 0;
        end
      end else if (m_st == 1) begin
        if (m_q.size() == FD) m_st = 2;
      end else if (acc && px[24]) begin
        m_st = 1;
      end
      if (acc && (st0 != 0 || px[24])) m_q.push_back(px);
    end
    if (acc) pp = src_q.pop_front();
    @(negedge clk);
    a = {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N,
         bus.valid, bus.underflow, bus.sof_err, bus.frame_done};
    check_eq("outputs", {1'b0, a}, {1'b0, e});
    per_cyc++;
    if (!bus.VGA_HS) hs_lo++;
    if (!bus.VGA_VS) vs_lo++;
    if (!bus.VGA_BLANK_N) bl_lo++;
    if (bus.valid) begin
      vcnt++;
      if (!bus.underflow) shown++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_rgb  = a[30:7];
      end
    end
    if (bus.underflow) uf++;
    if (bus.sof_err) begin
      se++;
      se_pos.push_back(vcnt);
    end
    if (bus.frame_done) begin
      fd_n++;
      check_eq("valid_per_frame", vcnt, 12);
      if (fd_n > 1) begin
        check_eq("frame_period", per_cyc, 42);
        check_eq("hs_low_per_frame", hs_lo, 6);
        check_eq("vs_low_per_frame", vs_lo, 7);
        check_eq("blank_low_per_frame", bl_lo, 30);
      end
      vcnt = 0; per_cyc = 0; hs_lo = 0; vs_lo = 0; bl_lo = 0;
    end
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    repeat (n) cycle();
    reset_n = 1'b1;
    clear_stats();
  endtask

  task automatic run_frames(input int n, input int budget);
    int k = 0;
    while (fd_n < n && k < budget) begin
      cycle();
      k++;
    end
    check_eq("frames_done", fd_n, n);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_r     = '0;
    bus.in_g     = '0;
    bus.in_b     = '0;
    clear_stats();
    @(negedge clk);

    // Reset with input offered, then alignment and backpressure over 3 frames.
    src_q.push_back({1'b0, 24'hEEEEEE});
    src_q.push_back({1'b0, 24'hEEEEEE});
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 12; k++) src_q.push_back(mkpix(f, k, k == 0));
    reset_n = 1'b0;
    repeat (3) cycle();
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("rst_hs", {31'b0, bus.VGA_HS}, 32'd1);
    check_eq("rst_vs", {31'b0, bus.VGA_VS}, 32'd1);
    check_eq("rst_blank_n", {31'b0, bus.VGA_BLANK_N}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.valid}, 32'd0);
    reset_n = 1'b1;
    clear_stats();
    run_frames(3, 300);
    check_eq("first_pixel", {8'h0, first_rgb}, 32'h010203);
    check_eq("bp_pixels_shown", shown, 36);
    check_eq("bp_src_drained", src_q.size(), 0);
    check_eq("bp_ready_dropped", {31'b0, rdy_lo_scan > 0}, 32'd1);
    check_eq("align_underflow", uf, 0);
    check_eq("align_sof_err", se, 0);

    // Underflow: only 6 pixels of the frame arrive.
    for (int k = 0; k < 6; k++) src_q.push_back(mkpix(5, k, k == 0));
    apply_reset(2);
    run_frames(1, 200);
    check_eq("uf_frame1", uf, 6);
    check_eq("uf_shown", shown, 6);
    run_frames(2, 100);
    check_eq("uf_two_frames", uf, 18);

    // Misaligned marker on the 5th pixel, then a frame with no marker at all.
    for (int k = 0; k < 12; k++) src_q.push_back(mkpix(7, k, (k == 0) || (k == 4)));
    for (int k = 0; k < 12; k++) src_q.push_back(mkpix(8, k, 1'b0));
    apply_reset(2);
    run_frames(2, 200);
    check_eq("sof_err_count", se, 2);
    check_eq("sof_err_pos0", (se_pos.size() > 0) ? se_pos[0] : -1, 5);
    check_eq("sof_err_pos1", (se_pos.size() > 1) ? se_pos[1] : -1, 1);
    check_eq("misalign_underflow", uf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
